// File: rtl/stream_ctrl_pkg.sv
// stream_ctrl_pkg: state encoding, parameter defaults and source-priority helper
package stream_ctrl_pkg;
    localparam int N_SRC_DEF = 2;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;
    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction
endpackage

// File: rtl/stream_ctrl_if.sv
// stream_ctrl_if: source-select and buffer-write signals between controller and datapath
interface stream_ctrl_if #(
    parameter int N_SRC = 2,
    parameter int DATA_W = 16
) ();
    logic [N_SRC-1:0]        src_en;
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;
    logic                    buf_full;
    logic                    buf_empty;
    logic                    rd_valid;
    modport master (
        output src_en, wr_en, wr_data,
        input  src_valid, src_data, buf_full, buf_empty, rd_valid
    );
    modport slave (
        input  src_en, wr_en, wr_data,
        output src_valid, src_data, buf_full, buf_empty, rd_valid
    );
endinterface

// File: rtl/stream_ctrl_edge_det.sv
// edge_det: rising-edge detector that only fires after the input has been seen low
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic din_q;
    logic armed;
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            din_q <= din;
            armed <= armed | ~din;
        end
    end
    // armed keeps a level held high across reset from looking like a fresh edge
    assign rise = din & ~din_q & armed;
endmodule

// File: rtl/stream_ctrl.sv
// stream_ctrl: selects one sequence source per run and streams its words into a buffer
module stream_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    localparam int SEL_W = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] start,
    input  logic             stop,
    stream_ctrl_if.master    bus,
    output logic [1:0]       state,
    output logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] word_cnt,
    output logic             drop
);
    state_t st, st_nxt;
    logic [N_SRC-1:0] start_rise;
    logic stop_rise;
    logic run_ok;
    logic go;
    for (genvar g = 0; g < N_SRC; g++) begin : g_start
        edge_det u_edge (.clk, .rst, .din(start[g]), .rise(start_rise[g]));
    end
    edge_det u_stop (.clk, .rst, .din(stop), .rise(stop_rise));
    assign state = st;
    assign go = st == IDLE && |start_rise;
    assign run_ok = st == RUN && !bus.buf_full;
    assign bus.src_en = run_ok ? N_SRC'(1) << sel : '0;
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:      st_nxt = |start_rise ? RUN : IDLE;
            RUN, HOLD: st_nxt = stop_rise ? DRAIN : bus.buf_full ? HOLD : RUN;
            DRAIN:     st_nxt = bus.buf_empty && !bus.rd_valid ? IDLE : DRAIN;
            default:   st_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            sel         <= '0;
            word_cnt    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_data <= '0;
            drop        <= 1'b0;
        end else begin
            st          <= st_nxt;
            sel         <= go ? SEL_W'(lowest_idx(8'(start_rise))) : sel;
            word_cnt    <= go ? '0 : (bus.wr_en && !(&word_cnt)) ? word_cnt + 1'b1 : word_cnt;
            bus.wr_en   <= run_ok && bus.src_valid[sel];
            bus.wr_data <= bus.src_data[sel*DATA_W +: DATA_W];
            drop        <= bus.src_valid[sel] && st != IDLE && !run_ok;
        end
    end
endmodule

// File: tb/tb_stream_ctrl.sv
// tb_stream_ctrl: directed vector table plus randomized run against a behavioural model
module tb_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] start;
    logic stop;
    logic [1:0] state0, state1;
    logic sel0, sel1;
    logic [15:0] cnt0;
    logic [3:0] cnt1;
    logic drop0, drop1;

    stream_ctrl_if #(.N_SRC(2), .DATA_W(16)) bus0 ();
    stream_ctrl_if #(.N_SRC(2), .DATA_W(16)) bus1 ();
    assign bus1.src_valid = bus0.src_valid;
    assign bus1.src_data  = bus0.src_data;
    assign bus1.buf_full  = bus0.buf_full;
    assign bus1.buf_empty = bus0.buf_empty;
    assign bus1.rd_valid  = bus0.rd_valid;

    stream_ctrl #(.N_SRC(2), .DATA_W(16), .CNT_W(16)) d0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus0.master),
        .state(state0), .sel(sel0), .word_cnt(cnt0), .drop(drop0)
    );
    stream_ctrl #(.N_SRC(2), .DATA_W(16), .CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .bus(bus1.master),
        .state(state1), .sel(sel1), .word_cnt(cnt1), .drop(drop1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r, s, sp, v, f, e, rv;
        int st, sl, cnt, wr, dr, en;
    } vec_t;
    vec_t tbl[26];

    int checks = 0;
    int errors = 0;
    bit warm = 1'b0;
    logic [1:0] en_seen;

    int m_st, m_sel, m_c16, m_c4;
    bit m_wr, m_drop;
    logic [15:0] m_wd;
    logic [1:0] pl_start;
    bit pl_stop;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    // Spec-level model: an edge needs a non-reset low sample the cycle before.
    task automatic model_step();
        logic [1:0] rs;
        bit rstop, ok, v;
        int nst, nsel;
        if (rst) begin
            m_st = 0; m_sel = 0; m_c16 = 0; m_c4 = 0;
            m_wr = 0; m_drop = 0; m_wd = '0;
            pl_start = 2'b00; pl_stop = 0;
        end else begin
            rs = start & pl_start;
            rstop = stop && pl_stop;
            ok = m_st == 1 && !bus0.buf_full;
            v = bus0.src_valid[m_sel];
            nsel = m_sel;
            if (m_st == 0) nst = rs != 0 ? 1 : 0;
            else if (m_st == 3) nst = (bus0.buf_empty && !bus0.rd_valid) ? 0 : 3;
            else nst = rstop ? 3 : bus0.buf_full ? 2 : 1;
            if (m_st == 0 && rs != 0) begin
                nsel = rs[0] ? 0 : 1;
                m_c16 = 0;
                m_c4 = 0;
            end else if (m_wr) begin
                m_c16 = m_c16 < 65535 ? m_c16 + 1 : m_c16;
                m_c4 = m_c4 < 15 ? m_c4 + 1 : m_c4;
            end
            m_wd = bus0.src_data[16*m_sel +: 16];
            m_wr = ok && v;
            m_drop = v && m_st != 0 && !ok;
            m_st = nst;
            m_sel = nsel;
            pl_start = ~start;
            pl_stop = !stop;
        end
    endtask

    task automatic cycle(input bit r, input logic [1:0] s, input bit sp, input logic [1:0] v,
                         input bit f, input bit e, input bit rv);
        logic [1:0] e_en;
        rst = r;
        start = s;
        stop = sp;
        bus0.src_valid = v;
        bus0.src_data = $urandom;
        bus0.buf_full = f;
        bus0.buf_empty = e;
        bus0.rd_valid = rv;
        #1;
        en_seen = bus0.src_en;
        e_en = 2'b00;
        if (m_st == 1 && !f) e_en[m_sel] = 1'b1;
        if (warm) begin
            chk("m_src_en", 32'(bus0.src_en), 32'(e_en));
            chk("m_src_en_w4", 32'(bus1.src_en), 32'(e_en));
        end
        @(posedge clk);
        model_step();
        warm = 1'b1;
        @(negedge clk);
        chk("m_state", 32'(state0), m_st);
        chk("m_state_w4", 32'(state1), m_st);
        chk("m_sel", 32'(sel0), m_sel);
        chk("m_sel_w4", 32'(sel1), m_sel);
        chk("m_cnt", 32'(cnt0), m_c16);
        chk("m_cnt_w4", 32'(cnt1), m_c4);
        chk("m_wr_en", 32'(bus0.wr_en), 32'(m_wr));
        chk("m_wr_en_w4", 32'(bus1.wr_en), 32'(m_wr));
        chk("m_wr_data", 32'(bus0.wr_data), 32'(m_wd));
        chk("m_drop", 32'(drop0), 32'(m_drop));
        chk("m_drop_w4", 32'(drop1), 32'(m_drop));
    endtask

    initial begin
        logic [1:0] rs;
        tbl = '{
            '{0,0,0,0,0,1,0, 0,0,0,0,0,0},
            '{0,2,0,2,0,1,0, 1,1,0,0,0,0},
            '{0,2,0,2,0,1,0, 1,1,0,1,0,2},
            '{0,2,0,2,0,1,0, 1,1,1,1,0,2},
            '{0,2,0,2,0,1,0, 1,1,2,1,0,2},
            '{0,2,0,2,0,1,0, 1,1,3,1,0,2},
            '{0,2,0,2,0,1,0, 1,1,4,1,0,2},
            '{0,2,0,0,0,1,0, 1,1,5,0,0,2},
            '{0,2,0,2,1,1,0, 2,1,5,0,1,0},
            '{0,2,0,2,1,1,0, 2,1,5,0,1,0},
            '{0,2,0,2,1,1,0, 2,1,5,0,1,0},
            '{0,2,0,0,0,1,0, 1,1,5,0,0,0},
            '{0,2,0,2,0,1,0, 1,1,5,1,0,2},
            '{0,2,1,2,1,1,0, 3,1,6,0,1,0},
            '{0,2,1,2,0,0,0, 3,1,6,0,1,0},
            '{0,2,0,0,0,1,1, 3,1,6,0,0,0},
            '{0,2,0,0,0,1,0, 0,1,6,0,0,0},
            '{0,2,0,2,0,1,0, 0,1,6,0,0,0},
            '{0,0,0,0,0,1,0, 0,1,6,0,0,0},
            '{0,3,0,2,0,1,0, 1,0,0,0,0,0},
            '{0,3,0,2,0,1,0, 1,0,0,0,0,1},
            '{0,3,0,2,0,1,0, 1,0,0,0,0,1},
            '{0,3,0,1,1,1,0, 2,0,0,0,1,0},
            '{1,3,0,1,1,1,0, 0,0,0,0,0,0},
            '{0,3,0,0,0,1,0, 0,0,0,0,0,0},
            '{0,3,0,0,0,1,0, 0,0,0,0,0,0}
        };
        m_st = 0; m_sel = 0; m_c16 = 0; m_c4 = 0;
        m_wr = 0; m_drop = 0; m_wd = '0; pl_start = 2'b00; pl_stop = 0;
        @(negedge clk);
        cycle(1, 2'b00, 0, 2'b11, 0, 1, 0);
        cycle(1, 2'b00, 0, 2'b11, 0, 1, 0);
        chk("rst_state", 32'(state0), 0);
        chk("rst_sel", 32'(sel0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_wr_en", 32'(bus0.wr_en), 0);
        chk("rst_wr_data", 32'(bus0.wr_data), 0);
        chk("rst_drop", 32'(drop0), 0);
        for (int i = 0; i < 26; i++) begin
            cycle(tbl[i].r != 0, 2'(tbl[i].s), tbl[i].sp != 0, 2'(tbl[i].v),
                  tbl[i].f != 0, tbl[i].e != 0, tbl[i].rv != 0);
            chk($sformatf("t%0d_src_en", i), 32'(en_seen), tbl[i].en);
            chk($sformatf("t%0d_state", i), 32'(state0), tbl[i].st);
            chk($sformatf("t%0d_sel", i), 32'(sel0), tbl[i].sl);
            chk($sformatf("t%0d_cnt", i), 32'(cnt0), tbl[i].cnt);
            chk($sformatf("t%0d_cnt_w4", i), 32'(cnt1), tbl[i].cnt);
            chk($sformatf("t%0d_wr_en", i), 32'(bus0.wr_en), tbl[i].wr);
            chk($sformatf("t%0d_drop", i), 32'(drop0), tbl[i].dr);
        end
        cycle(0, 2'b00, 0, 2'b00, 0, 1, 0);
        cycle(0, 2'b01, 0, 2'b01, 0, 1, 0);
        for (int i = 0; i < 20; i++) cycle(0, 2'b01, 0, 2'b01, 0, 1, 0);
        cycle(0, 2'b01, 0, 2'b00, 0, 1, 0);
        cycle(0, 2'b01, 0, 2'b00, 0, 1, 0);
        chk("sat_cnt_w4", 32'(cnt1), 15);
        chk("sat_cnt_w16", 32'(cnt0), 20);
        cycle(0, 2'b00, 1, 2'b00, 0, 1, 0);
        chk("sat_drain", 32'(state0), 3);
        cycle(0, 2'b00, 0, 2'b00, 0, 1, 0);
        chk("sat_idle", 32'(state0), 0);
        chk("sat_hold_w4", 32'(cnt1), 15);
        rs = 2'b00;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) rs = 2'($urandom);
            cycle($urandom_range(0, 99) == 0, rs, $urandom_range(0, 15) == 0, 2'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_ctrl.md
STREAM_CTRL -- requirements
Module: stream_ctrl

Interface
REQ-001 Parameter N_SRC, default 2: number of selectable sequence sources, range 2..8.
REQ-002 Parameter DATA_W, default 16: source and buffer word width.
REQ-003 Parameter CNT_W, default 16: width of the per-run word counter.
REQ-004 Port clk  in  1: system clock; all logic on rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port start  in  N_SRC: per-source start request, raw level, edge-detected internally.
REQ-007 Port stop  in  1: stop request, raw level, edge-detected internally.
REQ-008 Port src_valid  in  N_SRC: per-source output-valid strobe.
REQ-009 Port src_data  in  N_SRC*DATA_W: packed source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port buf_full  in  1: downstream buffer full.
REQ-011 Port buf_empty  in  1: downstream buffer empty.
REQ-012 Port rd_valid  in  1: consumer side still presenting a word.
REQ-013 Port src_en  out  N_SRC: one-hot-or-zero source enable.
REQ-014 Port wr_en  out  1: buffer write strobe.
REQ-015 Port wr_data  out  DATA_W: buffer write data.
REQ-016 Port state  out  2: current FSM state.
REQ-017 Port sel  out  max(1,$clog2(N_SRC)): index of the active source.
REQ-018 Port word_cnt  out  CNT_W: words written in the current/last run.
REQ-019 Port drop  out  1: one-cycle pulse when a valid from the active source is discarded.

Function
REQ-020 FSM states: IDLE=0, RUN=1, HOLD=2, DRAIN=3; the state output reflects the registered state.
REQ-021 Rising edge = din & ~din_q, with din_q registered; one rising pulse per low-to-high transition.
REQ-022 IDLE: on any start rising edge, the lowest set index is latched into sel, word_cnt clears to 0, next state RUN.
REQ-023 Start edges in RUN, HOLD or DRAIN are ignored; sel does not change outside IDLE.
REQ-024 RUN: a stop edge goes to DRAIN (priority over full); else buf_full goes to HOLD; else the FSM stays in RUN.
REQ-025 HOLD: a stop edge goes to DRAIN; else !buf_full returns to RUN.
REQ-026 DRAIN: buf_empty && !rd_valid goes to IDLE; else the FSM stays in DRAIN.
REQ-027 src_en[sel]=1 only when state==RUN && !buf_full (combinational on buf_full); all other bits 0.
REQ-028 Write strobe: wr_en <= (state==RUN) && src_valid[sel] && !buf_full; wr_data <= slice sel of src_data; latency 1 cycle.
REQ-029 src_valid of unselected sources is ignored entirely.
REQ-030 drop <= src_valid[sel] && state!=IDLE && !(state==RUN && !buf_full); registered, 1-cycle latency.
REQ-031 word_cnt increments by 1 on each cycle wr_en=1, saturates at all-ones, and holds its value through DRAIN and IDLE until the next start.
REQ-032 A stop edge and buf_full in the same RUN cycle: the next state is DRAIN; no write that cycle if buf_full.

Reset
REQ-033 rst forces state=IDLE, sel=0, word_cnt=0, wr_en=0, wr_data=0, drop=0, and all edge-detector registers to 0.
REQ-034 rst mid-run takes priority over all transitions; src_en is 0 in the cycle after rst is sampled.

Structure
REQ-035 Package stream_ctrl_pkg holds the state encoding constants and the defaults for N_SRC/DATA_W/CNT_W.
REQ-036 Sub-module edge_det (clk, rst, din, rise) is instantiated N_SRC+1 times.

Verification
REQ-037 N_SRC=2, start[1] rises in IDLE with src_valid[1] asserted for 5 cycles -> state goes 0->1, sel=1, 5 wr_en pulses, word_cnt=5.
REQ-038 start=2'b11 in the same cycle -> sel=0; src_valid[1] activity yields no wr_en.
REQ-039 buf_full asserted in RUN for 3 cycles while src_valid[sel]=1 -> state=2, src_en=0, wr_en=0, 3 drop pulses, then return to RUN.
REQ-040 stop edge with buf_full=1 -> DRAIN; with buf_empty=0 or rd_valid=1 it stays in DRAIN; both clear -> IDLE one cycle later.
REQ-041 CNT_W=4 with 20 valid words -> word_cnt saturates at 15.
REQ-042 rst asserted in HOLD -> next cycle state=0, word_cnt=0, src_en=0; start held high across reset produces no start edge.
